// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
// Shadow destinations are stored at DEST_W bits; REG_AW must not exceed it.
package pipeline_ctrl_pkg;

  localparam int DEST_W = 8;

  localparam logic [DEST_W-1:0] REG_ZERO = '0;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } muldiv_state_t;

  typedef struct packed {
    logic              valid;
    logic              rf_en;
    logic              load;
    logic [DEST_W-1:0] dest;
  } shadow_t;

  localparam shadow_t SHADOW_NONE = '0;

endpackage

// File: rtl/pipeline_hazard_ctrl_muldiv_sequencer.sv
// HI/LO multiply/divide sequencer: busy for MULDIV_LAT cycles after start,
// with a one-cycle done pulse in the last busy cycle.
module muldiv_sequencer
  import pipeline_ctrl_pkg::*;
#(
  parameter int MULDIV_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done
);

  localparam int CNT_W = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 1);

  muldiv_state_t state, state_nxt;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= MD_IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (state == MD_IDLE && start)
        count <= CNT_LOAD;
      else if (state == MD_BUSY && count != '0)
        count <= count - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (start) state_nxt = MD_BUSY;
      MD_BUSY: if (count == '0) state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == MD_BUSY);
    done = (state == MD_BUSY) && (count == '0);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use and
// mult/div stalls, ALU operand forwarding, and taken-branch hold across stalls.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MULDIV_LAT = 4,
  parameter int REG_AW     = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_rf_enable,
  input  logic              id_load,
  input  logic              id_hilo_read,
  input  logic              id_muldiv_start,
  input  logic              ex_branch_taken,
  output logic              pc_enable,
  output logic              ifid_enable,
  output logic              idex_bubble,
  output logic              pc_sel_target,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              muldiv_busy,
  output logic              muldiv_done
);

  shadow_t s_ex, s_mem, s_wb;
  logic    branch_pending;
  logic    load_use_stall, muldiv_stall, stall, muldiv_start;

  logic [DEST_W-1:0] rs_w, rt_w;
  assign rs_w = DEST_W'(id_rs);
  assign rt_w = DEST_W'(id_rt);

  function automatic logic match(input shadow_t s, input logic [DEST_W-1:0] r);
    return s.valid && s.rf_en && (s.dest == r) && (r != REG_ZERO);
  endfunction

  function automatic logic [1:0] fwd_pick(input logic uses, input logic [DEST_W-1:0] r,
                                          input shadow_t ex, input shadow_t mem,
                                          input shadow_t wb);
    if (!uses)                         return FWD_RF;
    else if (match(ex, r) && !ex.load) return FWD_EX;
    else if (match(mem, r))            return FWD_MEM;
    else if (match(wb, r))             return FWD_WB;
    else                               return FWD_RF;
  endfunction

  always_comb begin
    load_use_stall = id_valid && s_ex.load &&
                     ((id_uses_rs && match(s_ex, rs_w)) || (id_uses_rt && match(s_ex, rt_w)));
    muldiv_stall   = id_valid && muldiv_busy && (id_hilo_read || id_muldiv_start);
    stall          = load_use_stall || muldiv_stall;
    muldiv_start   = id_valid && id_muldiv_start && !stall;
  end

  // Later stages never stall, so the shadow scoreboard advances every clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_ex  <= SHADOW_NONE;
      s_mem <= SHADOW_NONE;
      s_wb  <= SHADOW_NONE;
    end else begin
      s_wb  <= s_mem;
      s_mem <= s_ex;
      if (stall)
        s_ex <= SHADOW_NONE;
      else
        s_ex <= '{valid: id_valid, rf_en: id_rf_enable, load: id_load,
                  dest: DEST_W'(id_dest)};
    end
  end

  // A branch resolved during a stall is remembered and applied on release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      branch_pending <= 1'b0;
    else if (pc_enable)
      branch_pending <= 1'b0;
    else if (ex_branch_taken)
      branch_pending <= 1'b1;
  end

  always_comb begin
    pc_enable     = !reset && !stall;
    ifid_enable   = !reset && !stall;
    idex_bubble   = reset || stall || !id_valid;
    pc_sel_target = pc_enable && (ex_branch_taken || branch_pending);
    fwd_a_sel     = fwd_pick(id_uses_rs, rs_w, s_ex, s_mem, s_wb);
    fwd_b_sel     = fwd_pick(id_uses_rt, rt_w, s_ex, s_mem, s_wb);
  end

  muldiv_sequencer #(
    .MULDIV_LAT(MULDIV_LAT)
  ) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .start (muldiv_start),
    .busy  (muldiv_busy),
    .done  (muldiv_done)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl with hand-computed expectations.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_uses_rs, id_uses_rt, id_rf_enable, id_load;
  logic       id_hilo_read, id_muldiv_start, ex_branch_taken;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       pc_enable, ifid_enable, idex_bubble, pc_sel_target;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       muldiv_busy, muldiv_done;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MULDIV_LAT(4), .REG_AW(5)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_dest         (id_dest),
    .id_rf_enable    (id_rf_enable),
    .id_load         (id_load),
    .id_hilo_read    (id_hilo_read),
    .id_muldiv_start (id_muldiv_start),
    .ex_branch_taken (ex_branch_taken),
    .pc_enable       (pc_enable),
    .ifid_enable     (ifid_enable),
    .idex_bubble     (idex_bubble),
    .pc_sel_target   (pc_sel_target),
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel),
    .muldiv_busy     (muldiv_busy),
    .muldiv_done     (muldiv_done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] dest,
                        input logic rfen, input logic ld, input logic hilo, input logic mds);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_dest = dest; id_rf_enable = rfen; id_load = ld; id_hilo_read = hilo;
    id_muldiv_start = mds;
  endtask

  task automatic id_clear;
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain;
    id_clear();
    ex_branch_taken = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    id_clear();
    ex_branch_taken = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({pc_enable, ifid_enable, idex_bubble} !== 3'b001) begin
      errors++; $display("FAIL reset_enables got=%b want=001", {pc_enable, ifid_enable, idex_bubble});
    end
    vectors++;
    if (pc_sel_target !== 1'b0) begin
      errors++; $display("FAIL reset_pcsel got=%b want=0", pc_sel_target);
    end
    vectors++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
      errors++; $display("FAIL reset_fwd got=%b want=0000", {fwd_a_sel, fwd_b_sel});
    end
    vectors++;
    if ({muldiv_busy, muldiv_done} !== 2'b00) begin
      errors++; $display("FAIL reset_muldiv got=%b want=00", {muldiv_busy, muldiv_done});
    end
    ex_branch_taken = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_load_use;
    drain();
    id_set(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    #1;
    vectors++;
    if ({pc_enable, ifid_enable, idex_bubble} !== 3'b110) begin
      errors++; $display("FAIL lu_issue got=%b want=110", {pc_enable, ifid_enable, idex_bubble});
    end
    tick();
    id_set(1, 5, 0, 1, 0, 6, 1, 0, 0, 0);
    #1;
    vectors++;
    if ({pc_enable, ifid_enable, idex_bubble} !== 3'b001) begin
      errors++; $display("FAIL lu_stall got=%b want=001", {pc_enable, ifid_enable, idex_bubble});
    end
    tick();
    #1;
    vectors++;
    if ({pc_enable, ifid_enable, idex_bubble} !== 3'b110) begin
      errors++; $display("FAIL lu_release got=%b want=110", {pc_enable, ifid_enable, idex_bubble});
    end
    vectors++;
    if (fwd_a_sel !== 2'b10) begin
      errors++; $display("FAIL lu_fwd_mem got=%b want=10", fwd_a_sel);
    end
    tick();
  endtask

  task automatic test_forward;
    drain();
    id_set(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    tick();
    id_set(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    tick();
    id_set(1, 3, 3, 1, 1, 4, 0, 0, 0, 0);
    #1;
    vectors++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b0101) begin
      errors++; $display("FAIL fwd_ex got=%b want=0101", {fwd_a_sel, fwd_b_sel});
    end
    tick();
    #1;
    vectors++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b1010) begin
      errors++; $display("FAIL fwd_mem got=%b want=1010", {fwd_a_sel, fwd_b_sel});
    end
    tick();
    #1;
    vectors++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b1111) begin
      errors++; $display("FAIL fwd_wb got=%b want=1111", {fwd_a_sel, fwd_b_sel});
    end
    drain();
    id_set(1, 0, 0, 1, 1, 0, 1, 0, 0, 0);
    repeat (3) tick();
    #1;
    vectors++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
      errors++; $display("FAIL fwd_r0 got=%b want=0000", {fwd_a_sel, fwd_b_sel});
    end
    drain();
    id_set(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
    tick();
    id_set(1, 2, 2, 0, 1, 4, 0, 0, 0, 0);
    #1;
    vectors++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b0001) begin
      errors++; $display("FAIL fwd_uses got=%b want=0001", {fwd_a_sel, fwd_b_sel});
    end
    tick();
  endtask

  task automatic test_muldiv;
    drain();
    id_set(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    vectors++;
    if ({pc_enable, muldiv_busy} !== 2'b10) begin
      errors++; $display("FAIL md_issue got=%b want=10", {pc_enable, muldiv_busy});
    end
    tick();
    id_clear();
    #1;
    vectors++;
    if ({muldiv_busy, muldiv_done, pc_enable} !== 3'b101) begin
      errors++; $display("FAIL md_busy_nop got=%b want=101", {muldiv_busy, muldiv_done, pc_enable});
    end
    tick();
    id_set(1, 0, 0, 0, 0, 8, 1, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if ({pc_enable, idex_bubble, muldiv_done} !== {2'b01, (k == 2)}) begin
        errors++;
        $display("FAIL md_mfhi_stall k=%0d got=%b want=01%b", k,
                 {pc_enable, idex_bubble, muldiv_done}, (k == 2));
      end
      tick();
    end
    #1;
    vectors++;
    if ({pc_enable, idex_bubble, muldiv_busy, muldiv_done} !== 4'b1000) begin
      errors++;
      $display("FAIL md_mfhi_issue got=%b want=1000", {pc_enable, idex_bubble, muldiv_busy, muldiv_done});
    end
    tick();
  endtask

  task automatic test_back_to_back;
    int budget;
    drain();
    id_set(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++;
      if (pc_enable !== 1'b0) begin
        errors++; $display("FAIL b2b_stall k=%0d got=%b want=0", k, pc_enable);
      end
      tick();
    end
    #1;
    vectors++;
    if ({pc_enable, muldiv_busy} !== 2'b10) begin
      errors++; $display("FAIL b2b_start got=%b want=10", {pc_enable, muldiv_busy});
    end
    tick();
    id_clear();
    #1;
    vectors++;
    if (muldiv_busy !== 1'b1) begin
      errors++; $display("FAIL b2b_busy2 got=%b want=1", muldiv_busy);
    end
    budget = 0;
    while (muldiv_busy === 1'b1 && budget < 10) begin
      tick();
      budget++;
    end
    vectors++;
    if (budget != 4) begin
      errors++; $display("FAIL b2b_drain got=%0d cycles want=4", budget);
    end
  endtask

  task automatic test_branch_stall;
    drain();
    ex_branch_taken = 1'b1;
    #1;
    vectors++;
    if (pc_sel_target !== 1'b1) begin
      errors++; $display("FAIL br_direct got=%b want=1", pc_sel_target);
    end
    tick();
    ex_branch_taken = 1'b0;
    #1;
    vectors++;
    if (pc_sel_target !== 1'b0) begin
      errors++; $display("FAIL br_direct_clear got=%b want=0", pc_sel_target);
    end
    id_set(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
    tick();
    id_set(1, 7, 0, 1, 0, 6, 1, 0, 0, 0);
    ex_branch_taken = 1'b1;
    #1;
    vectors++;
    if ({pc_enable, pc_sel_target} !== 2'b00) begin
      errors++; $display("FAIL br_in_stall got=%b want=00", {pc_enable, pc_sel_target});
    end
    tick();
    ex_branch_taken = 1'b0;
    #1;
    vectors++;
    if ({pc_enable, pc_sel_target, idex_bubble} !== 3'b110) begin
      errors++;
      $display("FAIL br_release got=%b want=110", {pc_enable, pc_sel_target, idex_bubble});
    end
    tick();
    id_set(1, 6, 0, 1, 0, 9, 0, 0, 0, 0);
    #1;
    vectors++;
    if ({pc_sel_target, fwd_a_sel} !== 3'b001) begin
      errors++; $display("FAIL br_once_slot got=%b want=001", {pc_sel_target, fwd_a_sel});
    end
    tick();
  endtask

  task automatic test_reset_mid;
    drain();
    id_set(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    id_clear();
    tick();
    reset = 1'b1;
    #1;
    vectors++;
    if ({muldiv_busy, muldiv_done, pc_enable} !== 3'b000) begin
      errors++; $display("FAIL rst_mid got=%b want=000", {muldiv_busy, muldiv_done, pc_enable});
    end
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++;
      if ({muldiv_busy, muldiv_done} !== 2'b00) begin
        errors++; $display("FAIL rst_quiet k=%0d got=%b want=00", k, {muldiv_busy, muldiv_done});
      end
      tick();
    end
    id_set(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    vectors++;
    if ({pc_enable, muldiv_busy} !== 2'b10) begin
      errors++; $display("FAIL rst_restart got=%b want=10", {pc_enable, muldiv_busy});
    end
    tick();
    id_clear();
    #1;
    vectors++;
    if ({muldiv_busy, muldiv_done} !== 2'b10) begin
      errors++; $display("FAIL rst_busy got=%b want=10", {muldiv_busy, muldiv_done});
    end
    repeat (3) tick();
    #1;
    vectors++;
    if ({muldiv_busy, muldiv_done} !== 2'b11) begin
      errors++; $display("FAIL rst_done got=%b want=11", {muldiv_busy, muldiv_done});
    end
    tick();
    #1;
    vectors++;
    if (muldiv_busy !== 1'b0) begin
      errors++; $display("FAIL rst_idle got=%b want=0", muldiv_busy);
    end
  endtask

  task automatic test_idle_bubble;
    drain();
    id_set(0, 0, 0, 0, 0, 9, 1, 0, 0, 0);
    #1;
    vectors++;
    if ({pc_enable, ifid_enable, idex_bubble} !== 3'b111) begin
      errors++; $display("FAIL idle_bubble got=%b want=111", {pc_enable, ifid_enable, idex_bubble});
    end
    tick();
    id_set(1, 9, 0, 1, 0, 10, 0, 0, 0, 0);
    #1;
    vectors++;
    if ({fwd_a_sel, idex_bubble} !== 3'b000) begin
      errors++; $display("FAIL idle_sex_invalid got=%b want=000", {fwd_a_sel, idex_bubble});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forward();
    test_muldiv();
    test_back_to_back();
    test_branch_stall();
    test_reset_mid();
    test_idle_bubble();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
